// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: post-mortem instruction-trace recorder.
// Records the core trace stream into a circular buffer, freezes POST_TRIG
// words after the trap edge and plays the window back oldest-first over a
// valid/ready stream.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a 16-bit cycle stamp to
// every stored word; rd_data_o widens from 36 to 52 bits).
module trace_capture_buffer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int POST_TRIG  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  trace_valid_i,
  input  logic [35:0]           trace_data_i,
  input  logic                  trap_i,
  input  logic                  arm_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
`ifdef TRACE_TIMESTAMP_EN
  output logic [51:0]           rd_data_o,
`else
  output logic [35:0]           rd_data_o,
`endif
  output logic [1:0]            state_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  wrapped_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = 52;
`else
  localparam int DW = 36;
`endif
  localparam logic [DEPTH_LOG2:0]   DEPTH_C   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] POST_INIT = DEPTH_LOG2'(POST_TRIG);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2:0]     count_reg, count_next;
  logic                    wrapped_reg, wrapped_next;
  logic [DEPTH_LOG2-1:0]   post_cnt_reg, post_cnt_next;
  logic [DEPTH_LOG2-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]     fetch_rem_reg, fetch_rem_next;
  logic                    load_reg, load_next;
  logic                    rd_valid_reg, rd_valid_next;
  logic                    trap_q_reg;
  logic [DW-1:0]           rd_data_reg;
  logic                    trig;
  logic                    wr_en;
  logic                    rd_en;
  logic [DW-1:0]           wr_word;

  logic [DW-1:0]           mem [DEPTH];

  assign trig = trap_i & ~trap_q_reg;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_reg;

  // Free-running cycle stamp, wraps naturally at 16 bits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ts_reg <= '0;
    else          ts_reg <= ts_reg + 16'd1;
  end

  assign wr_word = {ts_reg, trace_data_i};
`else
  assign wr_word = trace_data_i;
`endif

  // Capture/readout control: next state plus all pointer and counter updates.
  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    wrapped_next   = wrapped_reg;
    post_cnt_next  = post_cnt_reg;
    rd_ptr_next    = rd_ptr_reg;
    fetch_rem_next = fetch_rem_reg;
    load_next      = 1'b0;
    rd_valid_next  = rd_valid_reg;
    wr_en          = 1'b0;
    rd_en          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (arm_i) begin
          wr_ptr_next   = '0;
          count_next    = '0;
          wrapped_next  = 1'b0;
          post_cnt_next = '0;
          state_next    = S_ARMED;
        end
      end
      S_ARMED, S_POST: begin
        if (arm_i) begin
          // Re-arm wins over any write or trigger in the same cycle.
          wr_ptr_next   = '0;
          count_next    = '0;
          wrapped_next  = 1'b0;
          post_cnt_next = '0;
          state_next    = S_ARMED;
        end else begin
          if (trace_valid_i) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (count_reg == DEPTH_C) wrapped_next = 1'b1;
            else                      count_next   = count_reg + CNT_ONE;
          end
          if (state_reg == S_ARMED) begin
            // The write in the trigger cycle is kept but not counted as post-trigger.
            if (trig) begin
              if (POST_TRIG == 0) begin
                state_next = S_DONE;
                load_next  = 1'b1;
              end else begin
                post_cnt_next = POST_INIT;
                state_next    = S_POST;
              end
            end
          end else if (trace_valid_i) begin
            post_cnt_next = post_cnt_reg - PTR_ONE;
            if (post_cnt_reg == PTR_ONE) begin
              state_next = S_DONE;
              load_next  = 1'b1;
            end
          end
        end
      end
      default: begin
        if (load_reg) begin
          // First DONE cycle: oldest word sits at wr_ptr once the buffer wrapped.
          rd_ptr_next    = wrapped_reg ? wr_ptr_reg : '0;
          fetch_rem_next = count_reg;
          if (count_reg == '0) state_next = S_IDLE;
        end else begin
          rd_en = (fetch_rem_reg != '0) && (!rd_valid_reg || rd_ready_i);
          if (rd_en) begin
            rd_ptr_next    = rd_ptr_reg + PTR_ONE;
            fetch_rem_next = fetch_rem_reg - CNT_ONE;
            rd_valid_next  = 1'b1;
          end else if (rd_valid_reg && rd_ready_i) begin
            rd_valid_next = 1'b0;
            state_next    = S_IDLE;
          end
        end
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      wrapped_reg   <= 1'b0;
      post_cnt_reg  <= '0;
      rd_ptr_reg    <= '0;
      fetch_rem_reg <= '0;
      load_reg      <= 1'b0;
      rd_valid_reg  <= 1'b0;
      trap_q_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      wrapped_reg   <= wrapped_next;
      post_cnt_reg  <= post_cnt_next;
      rd_ptr_reg    <= rd_ptr_next;
      fetch_rem_reg <= fetch_rem_next;
      load_reg      <= load_next;
      rd_valid_reg  <= rd_valid_next;
      trap_q_reg    <= trap_i;
    end
  end

  // Trace storage write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_word;
  end

  // Registered read; only loads on a fetch, so data holds during stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[rd_ptr_reg];
  end

  assign rd_valid_o = rd_valid_reg;
  assign rd_data_o  = rd_data_reg;
  assign state_o    = state_reg;
  assign count_o    = count_reg;
  assign wrapped_o  = wrapped_reg;

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Post-mortem instruction-trace recorder for the PicoRV32 demo system.
- Consumes the core's trace stream (trace_valid/trace_data) and trap flag.
- Stores the most recent trace words in a circular on-chip buffer and freezes a configurable number of words after the trap edge.
- Plays the frozen window back, oldest first, over a valid/ready stream for a downstream debug UART/JTAG bridge.

Parameters:
DEPTH_LOG2, 9, log2 of buffer depth in 36-bit words (DEPTH = 2**DEPTH_LOG2; must be ≥ 2).
POST_TRIG, 64, words captured after the trigger edge; legal range 0..DEPTH-1.

Ports:
clk_i  in  1  system clock (clk_125 domain).
rst_n_i  in  1  asynchronous active-low reset.
trace_valid_i  in  1  trace word valid from the core.
trace_data_i  in  36  trace word from the core.
trap_i  in  1  core trap flag (level).
arm_i  in  1  single-cycle pulse; clears the buffer and starts capture.
rd_ready_i  in  1  downstream ready.
rd_valid_o  out  1  readout word valid.
rd_data_o  out  36 (52 with TRACE_TIMESTAMP_EN)  readout word.
state_o  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
count_o  out  DEPTH_LOG2+1  words held; saturates at DEPTH.
wrapped_o  out  1  buffer has overwritten at least one word.

Behaviour:
- Reset (async, rst_n_i low): state IDLE; all pointers, count_o, wrapped_o, rd_valid_o and rd_data_o = 0; trap edge register = 0. Memory contents are not reset.
- Trap edge: trig = trap_i & ~trap_q. trap_q is registered every cycle in all states.
- IDLE:
  - No writes.
  - arm_i → ARMED; clears wr_ptr, count, wrapped and post counter.
  - If arm_i and trig occur in the same cycle, arm_i wins and the trigger is dropped.
- ARMED:
  - Each trace_valid_i writes mem[wr_ptr].
  - wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH.
  - wrapped_o is set when a write lands while count == DEPTH (stays set).
  - trig → POST with post_cnt = POST_TRIG. A write in the trigger cycle is stored but does not decrement post_cnt.
  - With POST_TRIG = 0, trig → DONE directly.
- POST:
  - Writes continue as in ARMED.
  - Each write decrements post_cnt; the write that brings post_cnt to 0 is stored, and the state goes to DONE the next cycle.
  - Further trig edges are ignored.
- arm_i in ARMED or POST restarts capture: same clearing as from IDLE; state → ARMED.
- DONE:
  - Trace input and arm_i are ignored.
  - On entry: rd_ptr = wrapped ? wr_ptr : 0; remaining = count.
  - Memory read is synchronous and the output is registered. First rd_valid_o appears 2 cycles after entering DONE.
  - rd_data_o holds stable while rd_valid_o & ~rd_ready_i.
  - A transfer occurs on rd_valid_o & rd_ready_i. rd_ptr advances modulo DEPTH and remaining decrements. Full throughput: one word per cycle while ready is held high.
  - After the last transfer: rd_valid_o = 0, state → IDLE. count_o and wrapped_o keep their values until the next arm_i.
  - If count = 0 on entry, go directly to IDLE with no rd_valid_o.
- Async reset at any point (including mid-readout) aborts immediately to the reset values.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - 16-bit free-running cycle counter (reset 0, wraps 0xFFFF→0).
  - The counter value is stored with every written word.
  - rd_data_o = {timestamp[15:0], trace[35:0]}, 52 bits.
- Undefined: no counter; rd_data_o is 36 bits; no timestamp storage.

Test Plan:
1. Basic capture (DEPTH_LOG2=4, POST_TRIG=4): arm, words 0..9, trap rises with valid low, words 10..13 → DONE; count_o=14, wrapped_o=0; readout with rd_ready_i=1 gives 0..13 on consecutive cycles, then IDLE.
2. Wrap: arm, words 0..29, trap, words 30..33 → count_o=16, wrapped_o=1; readout is 18..33 exactly.
3. Backpressure: in scenario 1 readout, toggle rd_ready_i 1,0,1,0… → each of 0..13 delivered exactly once; rd_data_o unchanged during every stalled cycle.
4. POST_TRIG=0 instance: arm, words 0..2, trap rises together with valid word 3 → DONE next cycle; readout 0..3, count_o=4.
5. Reset mid-readout: deassert rst_n_i after 3 transfers → rd_valid_o=0 and state_o=0 immediately; count_o=0; a new arm/capture behaves as scenario 1.
6. Trap already high when arm_i pulses → stays ARMED; trap low then high → POST; arm_i during POST → ARMED with count_o=0.
